apb_master_ctrl: RTL and testbench

Single-clock controller on the APB side of the ICB-to-APB bridge. Pops one command at a time from the read port of the command async FIFO, runs one APB3 transfer, and pushes the result into the response async FIFO. It is the sole reader of the command FIFO and the sole writer of the response FIFO in the APB clock domain, so it strictly serialises bus traffic.

---
 rtl/apb_ctrl_pkg.sv | 24 ++
 rtl/apb_timeout_cnt.sv | 41 ++++
 rtl/apb_master_ctrl.sv | 140 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and command-word field positions for the APB master controller.
// The response struct matches the default 32-bit APB data width.
package apb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } apb_state_e;

    localparam int CMD_WDATA_LSB = 32;
    localparam int CMD_ADDR_LSB  = 2;
    localparam int CMD_WRITE_BIT = 1;

    localparam int RSP_RDATA_W = 32;

    typedef struct packed {
        logic                   err;
        logic [RSP_RDATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles with pready low and flags expiry on the LIMIT-th such cycle.
// Cleared while the controller sits in SETUP.
module apb_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    input  logic pready,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run && !pready) begin
            // cnt_q holds the number of ACCESS cycles already spent waiting
            if (cnt_q == CW'(LIMIT - 1)) begin
                expired = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB-side controller of the ICB-to-APB bridge: one command in, one APB3 transfer, one response out.
// Optional ACCESS timeout is enabled with the APB_CTRL_TIMEOUT_EN macro.
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_WIDTH      = 64,
    parameter int RSP_WIDTH      = 33,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  prst_n,
    input  logic                  en,
    input  logic                  cmd_empty,
    input  logic [CMD_WIDTH-1:0]  cmd_data,
    output logic                  cmd_ren,
    input  logic                  rsp_full,
    output logic                  rsp_wen,
    output logic [RSP_WIDTH-1:0]  rsp_data,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy,
    output logic                  timeout_flag
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    apb_rsp_t              rsp_q, rsp_d;
    logic                  timeout_q, timeout_d;
    logic                  tmo_expired;
    logic                  unused_bits;

`ifdef APB_CTRL_TIMEOUT_EN
    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (pclk),
        .rst_n   (prst_n),
        .clr     (state_q == ST_SETUP),
        .run     (state_q == ST_ACCESS),
        .pready  (pready),
        .expired (tmo_expired)
    );
    assign unused_bits = cmd_data[0];
`else
    assign tmo_expired = 1'b0;
    assign unused_bits = cmd_data[0] ^ (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rsp_d     = rsp_q;
        timeout_d = timeout_q;
        cmd_ren   = 1'b0;
        rsp_wen   = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Full response FIFO blocks the fetch so RESP never has to stall
                cmd_ren = en && !cmd_empty && !rsp_full;
                if (cmd_ren) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                paddr_d  = {cmd_data[CMD_ADDR_LSB +: ADDR_WIDTH-2], 2'b00};
                pwrite_d = cmd_data[CMD_WRITE_BIT];
                pwdata_d = cmd_data[CMD_WDATA_LSB +: DATA_WIDTH];
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                psel    = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    rsp_d.err   = pslverr;
                    rsp_d.rdata = pwrite_q ? '0 : prdata;
                    state_d     = ST_RESP;
                end else if (tmo_expired) begin
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    timeout_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!rsp_full) begin
                    rsp_wen = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rsp_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rsp_q     <= rsp_d;
            timeout_q <= timeout_d;
        end
    end

    assign paddr        = paddr_q;
    assign pwrite       = pwrite_q;
    assign pwdata       = pwdata_q;
    assign rsp_data     = rsp_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: command FIFO and APB slave models plus a response scoreboard.
// Timeout scenarios are exercised when APB_CTRL_TIMEOUT_EN is defined.
module tb_apb_master_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 64;
    localparam int RW  = 33;
    localparam int TMO = 8;

    logic          pclk;
    logic          prst_n;
    logic          en;
    logic          cmd_empty;
    logic [CW-1:0] cmd_data;
    logic          cmd_ren;
    logic          rsp_full;
    logic          rsp_wen;
    logic [RW-1:0] rsp_data;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          busy;
    logic          timeout_flag;

    apb_master_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CMD_WIDTH      (CW),
        .RSP_WIDTH      (RW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk         (pclk),
        .prst_n       (prst_n),
        .en           (en),
        .cmd_empty    (cmd_empty),
        .cmd_data     (cmd_data),
        .cmd_ren      (cmd_ren),
        .rsp_full     (rsp_full),
        .rsp_wen      (rsp_wen),
        .rsp_data     (rsp_data),
        .paddr        (paddr),
        .pwrite       (pwrite),
        .psel         (psel),
        .penable      (penable),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc = cyc + 1;

    // ---------------- counters and check ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- models and scoreboard ----------------
    typedef struct {
        int          waits;
        logic [31:0] rd;
        logic        err;
    } slv_t;

    logic [CW-1:0] cmd_q[$];
    slv_t          slv_q[$];
    logic [CW-1:0] setup_q[$];
    logic [RW-1:0] exp_q[$];

    // A transfer times out when the slave inserts at least TMO wait states
    task automatic push_cmd(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                            input int waits, input logic [31:0] rd, input logic err);
        logic [CW-1:0] cmd;
        slv_t          s;
        bit            timed_out;
        cmd = {wdata, addr[31:2], wr, 1'($urandom_range(0, 1))};
        s.waits = waits;
        s.rd    = rd;
        s.err   = err;
        cmd_q.push_back(cmd);
        slv_q.push_back(s);
        setup_q.push_back(cmd);
`ifdef APB_CTRL_TIMEOUT_EN
        timed_out = (waits >= TMO);
`else
        timed_out = 1'b0;
`endif
        if (timed_out) exp_q.push_back({1'b1, 32'h0});
        else           exp_q.push_back({err, wr ? 32'h0 : rd});
    endtask

    // Registered-read command FIFO and APB slave; both update 1 time unit after the edge
    logic ren_seen = 1'b0;
    slv_t cur;
    int   waits_left = 0;

    always @(negedge pclk) ren_seen = cmd_ren;

    always @(posedge pclk) begin
        #1;
        if (ren_seen && cmd_q.size() > 0) cmd_data = cmd_q.pop_front();
        cmd_empty = (cmd_q.size() == 0);
        if (psel && !penable && slv_q.size() > 0) begin
            cur        = slv_q.pop_front();
            waits_left = cur.waits;
        end
        if (psel && penable) begin
            if (waits_left > 0) begin
                pready     = 1'b0;
                waits_left = waits_left - 1;
                prdata     = $urandom;
                pslverr    = 1'($urandom_range(0, 1));
            end else begin
                pready  = 1'b1;
                prdata  = cur.rd;
                pslverr = cur.err;
            end
        end else begin
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: responses against the scoreboard, APB setup phase against the issued command
    always @(negedge pclk) begin
        if (prst_n) begin
            if (rsp_wen) begin
                chk("rsp_wen_while_full", {63'h0, rsp_full}, 64'h0);
                if (exp_q.size() == 0) chk("unexpected_rsp", 64'h1, 64'h0);
                else                   chk("rsp_data", {31'h0, rsp_data}, {31'h0, exp_q.pop_front()});
            end
            if (psel && !penable) begin
                if (setup_q.size() == 0) begin
                    chk("unexpected_setup", 64'h1, 64'h0);
                end else begin
                    logic [CW-1:0] c;
                    c = setup_q.pop_front();
                    chk("paddr", {32'h0, paddr}, {32'h0, c[31:2], 2'b00});
                    chk("pwrite", {63'h0, pwrite}, {63'h0, c[1]});
                    chk("pwdata", {32'h0, pwdata}, {32'h0, c[63:32]});
                end
            end
            if (cmd_ren) chk("ren_cond", {63'h0, en & ~cmd_empty & ~rsp_full}, 64'h1);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #2;
    endtask

    task automatic wait_ren(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (cmd_ren) break;
        end
        if (i == 200) chk(tag, 64'h0, 64'h1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i;
        for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge pclk);
        chk(tag, 64'(exp_q.size()), 64'h0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t_rsp[$];
        int n_acc;
        int n_psel;
        bit saw_ren;
        logic [31:0] wd_seen;

        prst_n    = 1'b0;
        en        = 1'b0;
        rsp_full  = 1'b0;
        cmd_empty = 1'b1;
        cmd_data  = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #12;
        chk("rst_psel_penable", {62'h0, psel, penable}, 64'h0);
        chk("rst_paddr_pwrite", {31'h0, pwrite, paddr}, 64'h0);
        chk("rst_pwdata", {32'h0, pwdata}, 64'h0);
        chk("rst_ren_wen", {62'h0, cmd_ren, rsp_wen}, 64'h0);
        chk("rst_rsp_data", {31'h0, rsp_data}, 64'h0);
        chk("rst_busy_tmo", {62'h0, busy, timeout_flag}, 64'h0);
        tick(2);
        prst_n = 1'b1;
        en     = 1'b1;
        tick(2);
        chk("idle_empty_not_busy", {62'h0, busy, cmd_ren}, 64'h0);

        // Read with zero wait states: cycle-exact timeline from cmd_ren
        push_cmd(32'h1000_0010, 32'h0, 1'b0, 0, 32'hA5A5_5A5A, 1'b0);
        wait_ren("read_ren_timeout");
        @(negedge pclk);
        chk("read_t1_busy_psel", {62'h0, busy, psel}, 64'h2);
        @(negedge pclk);
        chk("read_t2_psel_penable", {62'h0, psel, penable}, 64'h2);
        @(negedge pclk);
        chk("read_t3_psel_penable", {62'h0, psel, penable}, 64'h3);
        chk("read_t3_paddr", {32'h0, paddr}, 64'h1000_0010);
        chk("read_t3_pwrite", {63'h0, pwrite}, 64'h0);
        @(negedge pclk);
        chk("read_t4_rsp_wen", {63'h0, rsp_wen}, 64'h1);
        chk("read_t4_rsp_data", {31'h0, rsp_data}, 64'h0_A5A5_5A5A);
        chk("read_t4_psel", {63'h0, psel}, 64'h0);
        tick(4);
        chk("read_paddr_hold", {32'h0, paddr}, 64'h1000_0010);

        // Write with 3 wait states
        push_cmd(32'h0000_0020, 32'h1234_5678, 1'b1, 3, $urandom, 1'b0);
        wait_ren("write_ren_timeout");
        n_acc = 0;
        wd_seen = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (psel && penable) begin
                n_acc = n_acc + 1;
                wd_seen = pwdata;
            end
            if (rsp_wen) break;
        end
        chk("write_access_len", 64'(n_acc), 64'd4);
        chk("write_pwdata", {32'h0, wd_seen}, 64'h1234_5678);
        chk("write_rsp_data", {31'h0, rsp_data}, 64'h0);
        tick(1);

        // Slave error on a read while the response FIFO is full before the fetch
        rsp_full = 1'b1;
        push_cmd(32'h0000_0044, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, 1'b1);
        saw_ren = 1'b0;
        repeat (10) begin
            @(negedge pclk);
            saw_ren = saw_ren | cmd_ren;
        end
        chk("bp_no_ren", {63'h0, saw_ren}, 64'h0);
        chk("bp_not_busy", {63'h0, busy}, 64'h0);
        tick(1);
        rsp_full = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (rsp_wen) break;
        end
        chk("err_bit32", {63'h0, rsp_data[32]}, 64'h1);
        tick(1);

        // Four queued commands, zero wait states
        for (int k = 0; k < 4; k++)
            push_cmd(32'h3000_0000 + 32'(k * 4), $urandom, 1'($urandom_range(0, 1)), 0, $urandom, 1'b0);
        n_psel = 0;
        t_rsp.delete();
        for (int i = 0; i < 100 && t_rsp.size() < 4; i++) begin
            @(negedge pclk);
            if (psel && !penable) n_psel = n_psel + 1;
            if (rsp_wen) t_rsp.push_back(cyc);
        end
        chk("b2b_psel_pulses", 64'(n_psel), 64'd4);
        chk("b2b_rsp_count", 64'(t_rsp.size()), 64'd4);
        for (int k = 1; k < t_rsp.size(); k++)
            chk("b2b_spacing", 64'(t_rsp[k] - t_rsp[k-1]), 64'd5);
        tick(2);

        // Asynchronous reset while in ACCESS
        push_cmd(32'h0000_0080, 32'h0, 1'b0, 5, $urandom, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (psel && penable) break;
        end
        #1;
        prst_n = 1'b0;
        #1;
        chk("rst_async_psel_penable", {62'h0, psel, penable}, 64'h0);
        chk("rst_async_busy", {63'h0, busy}, 64'h0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        tick(2);
        prst_n = 1'b1;
        tick(8);
        push_cmd(32'h0000_0090, 32'h0, 1'b0, 1, 32'h0BAD_F00D, 1'b0);
        wait_drain("post_reset_drain", 100);

`ifdef APB_CTRL_TIMEOUT_EN
        push_cmd(32'h0000_00A0, 32'h0, 1'b0, TMO - 1, 32'h7777_7777, 1'b0);
        wait_drain("tmo_edge_drain", 200);
        chk("tmo_edge_flag", {63'h0, timeout_flag}, 64'h0);
        push_cmd(32'h0000_00A4, 32'h0, 1'b0, TMO + 20, 32'h8888_8888, 1'b0);
        wait_drain("tmo_drain", 200);
        chk("tmo_rsp_data", {31'h0, rsp_data}, {31'h0, 1'b1, 32'h0});
        chk("tmo_flag_set", {63'h0, timeout_flag}, 64'h1);
        push_cmd(32'h0000_00A8, 32'h0, 1'b0, 0, 32'h9999_9999, 1'b0);
        wait_drain("tmo_after_drain", 200);
        chk("tmo_flag_sticky", {63'h0, timeout_flag}, 64'h1);
`else
        push_cmd(32'h0000_00A0, 32'h0, 1'b0, 12, 32'h7777_7777, 1'b0);
        wait_drain("long_wait_drain", 200);
        chk("no_tmo_flag", {63'h0, timeout_flag}, 64'h0);
`endif

        // Random traffic with en and rsp_full toggling
        for (int k = 0; k < 30; k++)
            push_cmd($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom, 1'($urandom_range(0, 1)));
        for (int g = 0; g < 3000 && exp_q.size() != 0; g++) begin
            en       = ($urandom_range(0, 3) != 0);
            rsp_full = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        en       = 1'b1;
        rsp_full = 1'b0;
        wait_drain("random_drain", 500);
        tick(3);
        chk("final_cmd_q_empty", 64'(cmd_q.size()), 64'h0);
        chk("final_setup_q_empty", 64'(setup_q.size()), 64'h0);
        chk("final_idle", {63'h0, busy}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
